dram_rd_responder: RTL and testbench

Behavioural-synthesisable DRAM read-channel responder: the memory end of the `araddr/arvalid/arready` + `rdata/rvalid/rlast` burst-read protocol driven by the input and weight buffers. It accepts one burst request at a time, waits a programmable access latency, then streams `BURST` words from an internal word array. It stands in for `dram0` (data) and `dram1` (weight) in block- and system-level benches, and as an on-chip scratch memory in FPGA builds. A side write port preloads feature maps and weights.

---
 rtl/dram_rd_responder.sv | 137 +++++++++++++
 tb/tb_dram_rd_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_rd_responder.sv
// Burst-read DRAM responder: accepts one araddr/arvalid request, waits LAT cycles,
// then streams BURST words (FIXED/INCR/WRAP) from a preloadable, never-reset word array.
module dram_rd_responder #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned BURST = 32,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned LAT   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] araddr,
    input  logic [3:0]    arburst,
    input  logic          arvalid,
    output logic          arready,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          rlast,
    input  logic          throttle,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);
    localparam int unsigned   DAW      = $clog2(DEPTH);
    localparam int unsigned   IW       = $clog2(BURST);
    localparam logic [IW-1:0] IDX_LAST = IW'(BURST - 1);
    localparam logic [3:0]    LAT_LAST = (LAT == 0) ? 4'd0 : 4'(LAT - 1);
    localparam logic [AW-1:0] WMASK    = AW'(BURST - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
    typedef enum logic [1:0] {T_FIXED = 2'b00, T_INCR = 2'b01, T_WRAP = 2'b10} btype_t;

    state_t          r_state, w_state_next;
    btype_t          r_type;
    logic [AW-1:0]   r_addr;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_lat;
    logic            r_arready, r_rvalid, r_rlast;
    logic [DW-1:0]   r_rdata;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_accept, w_emit, w_last;
    logic [AW-1:0]   w_sum, w_addr;
    logic [DAW-1:0]  w_beat_addr;
    logic            w_unused_bits;

    assign w_accept      = (r_state == S_IDLE) && arvalid;
    assign w_beat_addr   = w_addr[DAW-1:0];
    assign w_unused_bits = ^{arburst[3:2], w_addr[AW-1:DAW], waddr[AW-1:DAW]};

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rdata   = r_rdata;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Beat 0 is issued on the transition into BURST, so throttle only gates beats 1..BURST-1;
    // S_DONE covers the rlast cycle so arready reopens one cycle after it.
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arvalid) begin
                    if (LAT == 0) begin
                        w_emit       = 1'b1;
                        w_state_next = S_BURST;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_lat == LAT_LAST) begin
                    w_emit       = 1'b1;
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (!throttle) begin
                    w_emit = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_last       = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sum = r_addr + AW'(r_idx);
        case (r_type)
            T_FIXED: w_addr = r_addr;
            T_WRAP:  w_addr = (r_addr & ~WMASK) | (w_sum & WMASK);
            default: w_addr = w_sum;
        endcase
        if (r_state == S_IDLE) w_addr = araddr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_type    <= T_INCR;
            r_idx     <= '0;
            r_lat     <= '0;
        end else begin
            r_arready <= (w_state_next == S_IDLE);
            r_rvalid  <= w_emit;
            r_rlast   <= w_last;
            if (w_emit) r_rdata <= r_mem[w_beat_addr];
            if (w_accept) begin
                r_addr <= araddr;
                r_type <= btype_t'((arburst[1:0] == 2'b11) ? 2'b01 : arburst[1:0]);
                r_idx  <= (LAT == 0) ? IW'(1) : '0;
                r_lat  <= '0;
            end else begin
                if (r_state == S_WAIT) r_lat <= r_lat + 4'd1;
                if (w_emit)            r_idx <= r_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wen) r_mem[waddr[DAW-1:0]] <= wdata;
    end
endmodule

// File: tb/tb_dram_rd_responder.sv
// Scoreboard bench for dram_rd_responder: directed burst scenarios plus a random phase,
// checked against a shadow memory and spec-level beat address/timing model.
module tb_dram_rd_responder;
    localparam int unsigned DW = 32, AW = 32, BURST = 32, DEPTH = 4096, LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic [3:0]    arburst = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rvalid, rlast;
    logic          throttle = 1'b0;
    logic          wen = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;

    always #5 clk = ~clk;

    dram_rd_responder #(.DW(DW), .AW(AW), .BURST(BURST), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .araddr(araddr), .arburst(arburst), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
        .throttle(throttle), .wen(wen), .waddr(waddr), .wdata(wdata)
    );

    typedef struct { int unsigned addr; bit last; longint cyc; } beat_t;
    beat_t       sb[$];
    logic [31:0] shadow [DEPTH];
    bit          pv = 1'b0;
    int unsigned pa = 0;
    logic [31:0] pd = '0;
    longint      cyc = 0;
    bit          m_busy = 1'b0, mon_en = 1'b0, rw_en = 1'b0;
    int          thr_mode = 0;
    int          n_err = 0, n_chk = 0;

    // A write sampled at edge t becomes readable by the beat registered at edge t+1.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pv) shadow[pa] <= pd;
        pv <= wen;
        pa <= waddr % DEPTH;
        pd <= wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm, input string msg);
        n_chk++;
        n_err++;
        $display("FAIL %s: %s (cycle %0d)", nm, msg, cyc);
    endtask

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("arready", {63'd0, arready}, {63'd0, !m_busy});
                if (rvalid) begin
                    if (sb.size() == 0) begin
                        fail("unexpected_beat", "got rvalid=1 expected rvalid=0");
                    end else begin
                        e = sb.pop_front();
                        if (e.cyc >= 0) chk("beat_cycle", cyc, e.cyc);
                        chk("rdata", {32'd0, rdata}, {32'd0, shadow[e.addr]});
                        chk("rlast", {63'd0, rlast}, {63'd0, e.last});
                        if (e.last) m_busy = 1'b0;
                    end
                end else begin
                    chk("rlast_without_rvalid", {63'd0, rlast}, 64'd0);
                    if (sb.size() != 0 && sb[0].cyc >= 0 && sb[0].cyc <= cyc) begin
                        fail("missing_beat", $sformatf("got rvalid=0 expected beat addr %0h", sb[0].addr));
                        e = sb.pop_front();
                        if (e.last) m_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (thr_mode)
            1:       throttle = cyc[0];
            2:       throttle = 1'($urandom_range(0, 1));
            3:       throttle = 1'b1;
            default: throttle = 1'b0;
        endcase
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rw_en) begin
            wen   = ($urandom_range(0, 3) == 0);
            waddr = $urandom;
            wdata = $urandom;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Must be called at posedge+#1; returns at posedge+#1 of the cycle after acceptance.
    task automatic request(input logic [31:0] a, input logic [3:0] t, input bit keep, output longint k);
        int unsigned bound = 0;
        logic [31:0] s, ad;
        arvalid = 1'b1;
        araddr  = a;
        arburst = t;
        while (m_busy && bound < 2000) begin
            @(posedge clk);
            #1;
            bound++;
        end
        if (m_busy) begin
            fail("accept_timeout", "got no acceptance expected arready within 2000 cycles");
            arvalid = 1'b0;
            k = -1;
            return;
        end
        k = cyc;
        @(posedge clk);
        m_busy = 1'b1;
        for (int j = 0; j < int'(BURST); j++) begin
            s = a + 32'(j);
            case (t[1:0])
                2'b00:   ad = a;
                2'b10:   ad = (a & ~32'(BURST - 1)) | (s & 32'(BURST - 1));
                default: ad = s;
            endcase
            sb.push_back('{addr: ad % DEPTH, last: (j == int'(BURST) - 1),
                           cyc: ((thr_mode == 1 || thr_mode == 2) && j > 0) ? -1 : k + 1 + LAT + j});
        end
        #1;
        if (!keep) arvalid = 1'b0;
    endtask

    task automatic goto(input longint n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((sb.size() != 0 || m_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || m_busy) begin
            fail("drain_timeout", $sformatf("got %0d beats outstanding expected 0", sb.size()));
            sb.delete();
            m_busy = 1'b0;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int m);
        @(negedge clk);
        thr_mode = m;
        @(posedge clk);
        #1;
    endtask

    longint k, k1, k2;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_arready", {63'd0, arready}, 64'd1);
        chk("reset_rvalid", {63'd0, rvalid}, 64'd0);
        chk("reset_rlast", {63'd0, rlast}, 64'd0);
        chk("reset_rdata", {32'd0, rdata}, 64'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            wen   = 1'b1;
            waddr = ($urandom & ~32'(DEPTH - 1)) | i;
            wdata = (i < 64) ? 32'h100 + i : $urandom;
            @(posedge clk);
            #1;
        end
        wen = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        request(32'h5, 4'b0001, 1'b0, k);
        goto(k + 3);
        @(negedge clk);
        chk("incr5_first_data", {32'd0, rdata}, 64'h105);
        goto(k + 34);
        @(negedge clk);
        chk("incr5_last_data", {32'd0, rdata}, 64'h124);
        chk("incr5_last_rlast", {63'd0, rlast}, 64'd1);
        wait_idle();

        request(32'h25, 4'b1110, 1'b0, k);
        wait_idle();
        request(32'h10, 4'b0100, 1'b0, k);
        wait_idle();
        request(32'hABCD_0000 | (DEPTH - 2), 4'b0001, 1'b0, k);
        wait_idle();
        request(32'h33, 4'b1011, 1'b0, k);
        wait_idle();

        set_mode(1);
        request(32'h7, 4'b0001, 1'b0, k);
        wait_idle();
        set_mode(0);

        set_mode(3);
        request(32'h21, 4'b0010, 1'b0, k);
        repeat (LAT) @(negedge clk);
        thr_mode = 0;
        wait_idle();

        request(32'h0, 4'b0001, 1'b0, k);
        goto(k + 1 + LAT + 10);
        rst = 1'b1;
        @(posedge clk);
        sb.delete();
        m_busy = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("midrst_arready", {63'd0, arready}, 64'd1);
        chk("midrst_rlast", {63'd0, rlast}, 64'd0);
        wait_idle();
        request(32'h0, 4'b0001, 1'b0, k);
        goto(k + 1 + LAT);
        @(negedge clk);
        chk("post_rst_data0", {32'd0, rdata}, 64'h100);
        wait_idle();

        request(32'h40, 4'b0001, 1'b1, k1);
        request(32'h80, 4'b0001, 1'b0, k2);
        chk("b2b_accept_cycle", k2, k1 + LAT + BURST + 1);
        wait_idle();

        request(32'h10, 4'b0001, 1'b0, k);
        goto(k + LAT + 5);
        wen = 1'b1; waddr = 32'h15; wdata = 32'hA5A5_0015;
        @(posedge clk);
        #1;
        wen = 1'b0;
        @(negedge clk);
        chk("rbw_old", {32'd0, rdata}, 64'h115);
        goto(k + LAT + 7);
        wen = 1'b1; waddr = 32'h18; wdata = 32'hA5A5_0018;
        @(posedge clk);
        #1;
        wen = 1'b0;
        goto(k + LAT + 9);
        @(negedge clk);
        chk("rbw_new", {32'd0, rdata}, 64'hA5A5_0018);
        wait_idle();

        rw_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            set_mode(($urandom_range(0, 1) != 0) ? 2 : 0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            request($urandom, 4'($urandom_range(0, 15)), 1'b0, k);
            wait_idle();
        end
        rw_en = 1'b0;
        @(posedge clk);
        #1;
        wen = 1'b0;
        set_mode(0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
